// File: rtl/wb_burst_slave_mem.sv
// Wishbone B4 slave memory with registered-feedback bursts (classic, constant, linear and wrap-4/8/16),
// byte selects, configurable wait states before the first beat and error termination above DEPTH.
module wb_burst_slave_mem #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  we_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT        = 2'd1,
    S_CLASSIC_ACK = 2'd2,
    S_BURST       = 2'd3
  } state_t;

  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] L_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [2:0]          L_WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t                  r_state, r_state_next;
  logic                    r_ack, r_ack_next;
  logic                    r_err, r_err_next;
  logic [DATA_WIDTH-1:0]   r_dat, r_dat_next;
  logic [ADDR_WIDTH-1:0]   r_addr, r_addr_next;
  logic [2:0]              r_cnt, r_cnt_next;
  logic                    r_we, r_we_next;
  logic                    r_burst, r_burst_next;
  logic                    r_incr, r_incr_next;
  logic [1:0]              r_bte, r_bte_next;
  logic                    r_last, r_last_next;

  logic                    w_req;
  logic                    w_fire;
  logic                    w_wr;
  logic [ADDR_WIDTH-1:0]   w_beat_addr;
  logic                    w_beat_we;
  logic                    w_beat_burst;
  logic                    w_beat_incr;
  logic [1:0]              w_beat_bte;
  logic                    w_beat_err;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [DATA_WIDTH-1:0]   w_words [DEPTH];

  // Wrap bursts keep the upper address bits and count only the low bits selected by mask.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  incr,
    input logic [1:0]            bte
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc = a + ADDR_WIDTH'(1);
    case (bte)
      2'b01:   mask = ADDR_WIDTH'(3);
      2'b10:   mask = ADDR_WIDTH'(7);
      2'b11:   mask = ADDR_WIDTH'(15);
      default: mask = '1;
    endcase
    if (!incr) return a;
    return (a & ~mask) | (inc & mask);
  endfunction

  assign w_req        = cyc_i & stb_i;
  assign w_beat_addr  = (r_state == S_IDLE) ? adr_i : r_addr;
  assign w_beat_we    = (r_state == S_IDLE) ? we_i : r_we;
  assign w_beat_burst = (r_state == S_IDLE) ? ((cti_i == 3'b001) || (cti_i == 3'b010)) : r_burst;
  assign w_beat_incr  = (r_state == S_IDLE) ? (cti_i == 3'b010) : r_incr;
  assign w_beat_bte   = (r_state == S_IDLE) ? bte_i : r_bte;
  assign w_beat_err   = ({1'b0, w_beat_addr} >= L_DEPTH);
  assign w_idx        = w_beat_addr[IDX_W-1:0];
  assign w_rd_data    = w_words[w_idx];
  assign w_wr         = w_fire & ~w_beat_err & w_beat_we;

  always_comb begin
    r_state_next = r_state;
    r_ack_next   = 1'b0;
    r_err_next   = 1'b0;
    r_dat_next   = r_dat;
    r_addr_next  = r_addr;
    r_cnt_next   = r_cnt;
    r_we_next    = r_we;
    r_burst_next = r_burst;
    r_incr_next  = r_incr;
    r_bte_next   = r_bte;
    r_last_next  = r_last;
    w_fire       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          r_addr_next  = adr_i;
          r_we_next    = we_i;
          r_burst_next = w_beat_burst;
          r_incr_next  = w_beat_incr;
          r_bte_next   = bte_i;
          r_last_next  = 1'b0;
          r_cnt_next   = 3'd0;
          if (WAIT_STATES == 0) w_fire = 1'b1;
          else                  r_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          r_state_next = S_IDLE;
        end else if (r_cnt == L_WS_LAST) begin
          if (stb_i) w_fire = 1'b1;
        end else begin
          r_cnt_next = r_cnt + 3'd1;
        end
      end
      S_CLASSIC_ACK: r_state_next = S_IDLE;
      S_BURST: begin
        // r_last marks the cycle showing the final ack/err; no further beat is taken.
        if (!cyc_i || r_last) begin
          r_state_next = S_IDLE;
          r_last_next  = 1'b0;
        end else if (stb_i) begin
          w_fire = 1'b1;
        end
      end
      default: r_state_next = S_IDLE;
    endcase

    if (w_fire) begin
      if (w_beat_err) begin
        r_err_next = 1'b1;
        r_dat_next = '0;
      end else begin
        r_ack_next = 1'b1;
        if (!w_beat_we) r_dat_next = w_rd_data;
      end
      if (w_beat_burst) begin
        r_state_next = S_BURST;
        r_last_next  = w_beat_err | (cti_i == 3'b111);
        r_addr_next  = f_next_addr(w_beat_addr, w_beat_incr, w_beat_bte);
      end else begin
        r_state_next = S_CLASSIC_ACK;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_addr  <= '0;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_burst <= 1'b0;
      r_incr  <= 1'b0;
      r_bte   <= 2'b00;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_state_next;
      r_ack   <= r_ack_next;
      r_err   <= r_err_next;
      r_dat   <= r_dat_next;
      r_addr  <= r_addr_next;
      r_cnt   <= r_cnt_next;
      r_we    <= r_we_next;
      r_burst <= r_burst_next;
      r_incr  <= r_incr_next;
      r_bte   <= r_bte_next;
      r_last  <= r_last_next;
    end
  end

  // Storage is flops rather than block RAM so reset can clear every word.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] r_word;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_word <= '0;
        end else if (w_wr && (w_idx == IDX_W'(gi))) begin
          for (int b = 0; b < SEL_WIDTH; b++) begin
            if (sel_i[b]) r_word[8*b +: 8] <= dat_i[8*b +: 8];
          end
        end
      end
      assign w_words[gi] = r_word;
    end
  endgenerate

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign dat_o   = r_dat;
  assign state_o = r_state;

endmodule

// File: tb/tb_wb_burst_slave_mem.sv
// Directed bench for wb_burst_slave_mem: one zero-wait instance and one two-wait-state instance.
module tb_wb_burst_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [31:0] dat_w;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc0, stb0, cyc2, stb2;
  logic [31:0] dat0, dat2;
  logic        ack0, err0, ack2, err2;
  logic [1:0]  st0, st2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A0 = 32'hA0A0_A0A0;

  always #5 clk = ~clk;

  wb_burst_slave_mem #(.WAIT_STATES(0)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat0), .we_i(we),
    .sel_i(sel), .stb_i(stb0), .cyc_i(cyc0), .cti_i(cti), .bte_i(bte),
    .ack_o(ack0), .err_o(err0), .state_o(st0)
  );

  wb_burst_slave_mem #(.WAIT_STATES(2)) dut_ws (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat2), .we_i(we),
    .sel_i(sel), .stb_i(stb2), .cyc_i(cyc2), .cti_i(cti), .bte_i(bte),
    .ack_o(ack2), .err_o(err2), .state_o(st2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Classic single transaction on the selected instance; returns edges-to-termination (0 = none).
  task automatic txn(input int which, input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int lat, output logic got_ack,
                     output logic got_err, output logic [31:0] got_dat);
    adr = a; dat_w = d; we = w; sel = s; cti = 3'b000; bte = 2'b00;
    if (which == 0) begin cyc0 = 1'b1; stb0 = 1'b1; end
    else            begin cyc2 = 1'b1; stb2 = 1'b1; end
    lat = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (which == 0) begin got_ack = ack0; got_err = err0; got_dat = dat0; end
      else            begin got_ack = ack2; got_err = err2; got_dat = dat2; end
      if (got_ack || got_err) begin
        lat = i;
        break;
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
    $display("txn dut%0d we=%0b adr=%0d wdat=%h sel=%b lat=%0d ack=%0b err=%0b rdat=%h",
             which, w, a, d, s, lat, got_ack, got_err, got_dat);
    step();
  endtask

  int          lat;
  logic        gack, gerr;
  logic [31:0] gdat;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; adr = '0; dat_w = '0; we = 1'b0; sel = '0; cti = '0; bte = '0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
    step(); step();
    check_val("rst_ack", 32'(ack0), 32'd0);
    check_val("rst_err", 32'(err0), 32'd0);
    check_val("rst_dat", dat0, 32'd0);
    check_val("rst_state", 32'(st0), 32'd0);
    check_val("rst_state_ws", 32'(st2), 32'd0);
    rst = 1'b0;
    step();

    // 1: classic write then read, one-cycle latency
    txn(0, 1'b1, 5'd0, 32'h0000_1111, 4'hF, lat, gack, gerr, gdat);
    check_val("t1_wr_lat", 32'(lat), 32'd1);
    check_val("t1_wr_ack", 32'(gack), 32'd1);
    check_val("t1_ack_drop", 32'(ack0), 32'd0);
    check_val("t1_idle", 32'(st0), 32'd0);
    txn(0, 1'b0, 5'd0, 32'h0, 4'hF, lat, gack, gerr, gdat);
    check_val("t1_rd_dat", gdat, 32'h0000_1111);
    check_val("t1_rd_lat", 32'(lat), 32'd1);

    // 2: out-of-range address
    txn(0, 1'b1, 5'd20, 32'h0000_2222, 4'hF, lat, gack, gerr, gdat);
    check_val("t2_wr_err", 32'(gerr), 32'd1);
    check_val("t2_wr_ack", 32'(gack), 32'd0);
    check_val("t2_err_pulse", 32'(err0), 32'd0);
    txn(0, 1'b0, 5'd20, 32'h0, 4'hF, lat, gack, gerr, gdat);
    check_val("t2_rd_err", 32'(gerr), 32'd1);
    check_val("t2_rd_dat0", gdat, 32'd0);
    txn(0, 1'b0, 5'd4, 32'h0, 4'hF, lat, gack, gerr, gdat);
    check_val("t2_alias_unchanged", gdat, 32'd0);

    // 3: linear incrementing write burst at 3, four beats
    adr = 5'd3; we = 1'b1; sel = 4'hF; cti = 3'b010; bte = 2'b00; dat_w = A0;
    cyc0 = 1'b1; stb0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      $display("burst_wr beat=%0d ack=%0b state=%0d", i, ack0, st0);
      check_val("t3_ack", 32'(ack0), 32'd1);
      check_val("t3_state", 32'(st0), 32'd3);
      if (i < 3) begin
        dat_w = A0 + 32'(i + 1);
        cti   = (i == 2) ? 3'b111 : 3'b010;
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0; cti = 3'b000;
    step();
    check_val("t3_end_ack", 32'(ack0), 32'd0);
    check_val("t3_end_idle", 32'(st0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b0, 5'(3 + i), 32'h0, 4'hF, lat, gack, gerr, gdat);
      check_val("t3_readback", gdat, A0 + 32'(i));
    end

    // 4: wrap-4 read burst from 6 with a strobe gap
    txn(0, 1'b1, 5'd7, 32'h7777_7777, 4'hF, lat, gack, gerr, gdat);
    adr = 5'd6; we = 1'b0; cti = 3'b010; bte = 2'b01; cyc0 = 1'b1; stb0 = 1'b1;
    step();
    $display("wrap4 beat adr=6 ack=%0b dat=%h", ack0, dat0);
    check_val("t4_b0_ack", 32'(ack0), 32'd1);
    check_val("t4_b0_dat", dat0, A0 + 32'd3);
    step();
    $display("wrap4 beat adr=7 ack=%0b dat=%h", ack0, dat0);
    check_val("t4_b1_dat", dat0, 32'h7777_7777);
    stb0 = 1'b0;
    step();
    $display("wrap4 gap ack=%0b dat=%h", ack0, dat0);
    check_val("t4_gap_ack", 32'(ack0), 32'd0);
    check_val("t4_gap_hold", dat0, 32'h7777_7777);
    check_val("t4_gap_state", 32'(st0), 32'd3);
    stb0 = 1'b1;
    step();
    $display("wrap4 beat adr=4 ack=%0b dat=%h", ack0, dat0);
    check_val("t4_b2_ack", 32'(ack0), 32'd1);
    check_val("t4_b2_dat", dat0, A0 + 32'd1);
    cti = 3'b111;
    step();
    $display("wrap4 beat adr=5 ack=%0b dat=%h", ack0, dat0);
    check_val("t4_b3_dat", dat0, A0 + 32'd2);
    cyc0 = 1'b0; stb0 = 1'b0; cti = 3'b000; bte = 2'b00;
    step();
    check_val("t4_end_ack", 32'(ack0), 32'd0);
    check_val("t4_end_idle", 32'(st0), 32'd0);

    // 5: byte write on the two-wait-state instance
    txn(2, 1'b1, 5'd0, 32'h0000_1111, 4'hF, lat, gack, gerr, gdat);
    check_val("t5_wr_lat", 32'(lat), 32'd3);
    txn(2, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'b0010, lat, gack, gerr, gdat);
    check_val("t5_bwr_lat", 32'(lat), 32'd3);
    check_val("t5_bwr_ack", 32'(gack), 32'd1);
    adr = 5'd0; we = 1'b0; cti = 3'b000; cyc2 = 1'b1; stb2 = 1'b1;
    step();
    check_val("t5_w1_state", 32'(st2), 32'd1);
    check_val("t5_w1_ack", 32'(ack2), 32'd0);
    step();
    check_val("t5_w2_state", 32'(st2), 32'd1);
    check_val("t5_w2_ack", 32'(ack2), 32'd0);
    step();
    $display("ws_read adr=0 ack=%0b dat=%h state=%0d", ack2, dat2, st2);
    check_val("t5_rd_ack", 32'(ack2), 32'd1);
    check_val("t5_rd_state", 32'(st2), 32'd2);
    check_val("t5_rd_dat", dat2, 32'h0000_FF11);
    cyc2 = 1'b0; stb2 = 1'b0;
    step();

    // 6: asynchronous reset during read burst beat 2
    adr = 5'd3; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc0 = 1'b1; stb0 = 1'b1;
    step();
    check_val("t6_b0_dat", dat0, A0);
    step();
    check_val("t6_b1_dat", dat0, A0 + 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("async_reset ack=%0b err=%0b dat=%h state=%0d", ack0, err0, dat0, st0);
    check_val("t6_rst_ack", 32'(ack0), 32'd0);
    check_val("t6_rst_err", 32'(err0), 32'd0);
    check_val("t6_rst_dat", dat0, 32'd0);
    check_val("t6_rst_state", 32'(st0), 32'd0);
    step();
    check_val("t6_rst_held_ack", 32'(ack0), 32'd0);
    cyc0 = 1'b0; stb0 = 1'b0; cti = 3'b000; rst = 1'b0;
    step();
    txn(0, 1'b0, 5'd3, 32'h0, 4'hF, lat, gack, gerr, gdat);
    check_val("t6_clr_ack", 32'(gack), 32'd1);
    check_val("t6_clr_3", gdat, 32'd0);
    txn(0, 1'b0, 5'd7, 32'h0, 4'hF, lat, gack, gerr, gdat);
    check_val("t6_clr_7", gdat, 32'd0);
    txn(2, 1'b0, 5'd0, 32'h0, 4'hF, lat, gack, gerr, gdat);
    check_val("t6_clr_ws_0", gdat, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
